// File: rtl/hdlc_rx_pkg.sv
// Shared definitions for the HDLC receive deframer.
//   FLAG_PATTERN  : line pattern of an HDLC flag
//   ABORT_PATTERN : a zero followed by ABORT_ONES ones (oldest bit in MSB)
//   STUFF_ONES    : run of ones after which a transmitter inserts a zero
//   rx_state_t    : frame-tracking FSM states
package hdlc_rx_pkg;

    localparam logic [7:0] FLAG_PATTERN  = 8'b0111_1110;
    localparam int         ABORT_ONES    = 7;
    localparam int         STUFF_ONES    = 5;
    localparam logic [7:0] ABORT_PATTERN = {1'b0, {ABORT_ONES{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } rx_state_t;

endpackage

// File: rtl/hdlc_rx_pattern_detect.sv
// 8-bit receive window with registered flag/abort compare.
// Ports:
//   clk_i      : clock
//   clear_i    : synchronous clear (reset or receiver disabled)
//   rx_i       : serial line bit
//   flag_o     : one-cycle pulse, window held a flag in the previous cycle
//   abort_o    : one-cycle pulse, window held an abort in the previous cycle
//   exit_bit_o : bit that left the window, delayed one cycle so that it
//                lines up with flag_o/abort_o for the first bit of a pattern
module hdlc_rx_pattern_detect
    import hdlc_rx_pkg::*;
(
    input  logic clk_i,
    input  logic clear_i,
    input  logic rx_i,
    output logic flag_o,
    output logic abort_o,
    output logic exit_bit_o
);

    logic [7:0] win_q;
    logic       flag_q;
    logic       abort_q;
    logic       exit_q;

    // The window is cleared to ones (an idle, marking line) so that enabling
    // the receiver on an idle line does not see "0 then seven 1s" and report
    // a phantom abort. Newest bit enters at [0], oldest sits in [7].
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            win_q   <= 8'hFF;
            flag_q  <= 1'b0;
            abort_q <= 1'b0;
            exit_q  <= 1'b1;
        end else begin
            win_q   <= {win_q[6:0], rx_i};
            flag_q  <= (win_q == FLAG_PATTERN);
            abort_q <= (win_q == ABORT_PATTERN);
            exit_q  <= win_q[7];
        end
    end

    assign flag_o     = flag_q;
    assign abort_o    = abort_q;
    assign exit_bit_o = exit_q;

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero destuffing, LSB-first
// byte assembly and frame status toward the Rx buffer stage.
// Ports:
//   Clk, Rst (sync, active-low), RxEN (low clears everything), Rx (line bit)
//   Rx_FlagDetect / Rx_AbortDetect : pattern pulses
//   Rx_AbortSignal : abort while inside a frame
//   Rx_ValidFrame  : inside a frame
//   Rx_Data / Rx_WrBuff : assembled byte and its write strobe
//   Rx_EoF / Rx_FrameError : end of frame, with misalignment flag
//   Rx_Overflow    : byte beyond MAX_BYTES dropped
//   Rx_FrameSize   : byte count of the last completed frame
//
// state | meaning
// IDLE  | hunting for a flag, line bits ignored
// SYNC  | flag seen, no data bit yet (flag fill keeps us here)
// FRAME | data bits received since the opening flag
module hdlc_rx_deframer
    import hdlc_rx_pkg::*;
#(
    parameter int MAX_BYTES = 128,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             RxEN,
    input  logic             Rx,
    output logic             Rx_FlagDetect,
    output logic             Rx_AbortDetect,
    output logic             Rx_AbortSignal,
    output logic             Rx_ValidFrame,
    output logic [7:0]       Rx_Data,
    output logic             Rx_WrBuff,
    output logic             Rx_EoF,
    output logic             Rx_FrameError,
    output logic             Rx_Overflow,
    output logic [CNT_W-1:0] Rx_FrameSize
);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BYTES);
    localparam logic [2:0]       STUFF_CNT = 3'(STUFF_ONES);
    localparam logic [2:0]       ONES_SAT  = 3'(STUFF_ONES + 1);

    logic clear_d;
    logic flag_det;
    logic abort_det;
    logic exit_bit;

    rx_state_t        state_q;
    logic [2:0]       sup_q;
    logic [2:0]       ones_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_q;
    logic [CNT_W-1:0] byte_q;
    logic             valid_q;
    logic [7:0]       data_q;
    logic             wr_q;
    logic             eof_q;
    logic             ferr_q;
    logic             ovf_q;
    logic             asig_q;
    logic [CNT_W-1:0] size_q;

    logic       data_bit_d;
    logic       stuffed_d;
    logic [7:0] byte_d;

    assign clear_d = !Rst || !RxEN;

    hdlc_rx_pattern_detect u_detect (
        .clk_i      (Clk),
        .clear_i    (clear_d),
        .rx_i       (Rx),
        .flag_o     (flag_det),
        .abort_o    (abort_det),
        .exit_bit_o (exit_bit)
    );

    // A flag pulse coincides with the first flag bit leaving the window; that
    // bit and the seven after it belong to the flag and are not data. The
    // abort pulse likewise coincides with the abort's leading zero.
    assign data_bit_d = !flag_det && !abort_det && (sup_q == 3'd0);
    assign stuffed_d  = !exit_bit && (ones_q == STUFF_CNT);
    assign byte_d     = {exit_bit, shift_q[7:1]};

    always_ff @(posedge Clk) begin
        if (clear_d) begin
            state_q <= IDLE;
            sup_q   <= 3'd0;
            ones_q  <= 3'd0;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
            wr_q    <= 1'b0;
            eof_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            asig_q  <= 1'b0;
            size_q  <= '0;
        end else begin
            wr_q   <= 1'b0;
            eof_q  <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
            asig_q <= 1'b0;

            if (flag_det) begin
                sup_q <= 3'd7;
            end else if (sup_q != 3'd0) begin
                sup_q <= sup_q - 3'd1;
            end

            case (state_q)
                IDLE: begin
                    if (flag_det) begin
                        state_q <= SYNC;
                    end
                end
                SYNC, FRAME: begin
                    if (abort_det) begin
                        asig_q  <= (state_q == FRAME);
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                        ones_q  <= 3'd0;
                        shift_q <= 8'd0;
                        bit_q   <= 3'd0;
                        byte_q  <= '0;
                    end else if (flag_det) begin
                        if (state_q == FRAME) begin
                            eof_q  <= 1'b1;
                            ferr_q <= (bit_q != 3'd0);
                            size_q <= byte_q;
                        end
                        state_q <= SYNC;
                        valid_q <= 1'b0;
                        ones_q  <= 3'd0;
                        shift_q <= 8'd0;
                        bit_q   <= 3'd0;
                        byte_q  <= '0;
                    end else if (data_bit_d) begin
                        if (stuffed_d) begin
                            ones_q <= 3'd0;
                        end else begin
                            if (!exit_bit) begin
                                ones_q <= 3'd0;
                            end else if (ones_q != ONES_SAT) begin
                                ones_q <= ones_q + 3'd1;
                            end
                            state_q <= FRAME;
                            valid_q <= 1'b1;
                            shift_q <= byte_d;
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                // Past MAX_BYTES the count saturates and the
                                // byte is dropped; the frame itself continues.
                                if (byte_q == MAX_CNT) begin
                                    ovf_q <= 1'b1;
                                end else begin
                                    wr_q   <= 1'b1;
                                    data_q <= byte_d;
                                    byte_q <= byte_q + CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Rx_FlagDetect  = flag_det;
    assign Rx_AbortDetect = abort_det;
    assign Rx_AbortSignal = asig_q;
    assign Rx_ValidFrame  = valid_q;
    assign Rx_Data        = data_q;
    assign Rx_WrBuff      = wr_q;
    assign Rx_EoF         = eof_q;
    assign Rx_FrameError  = ferr_q;
    assign Rx_Overflow    = ovf_q;
    assign Rx_FrameSize   = size_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer. The reference model works on the recorded line
// history: a flag/abort is reported two cycles after the last bit of an
// 8-bit occurrence in the stream, and line bit p is judged (flag member,
// stuffed zero or data) nine cycles after it was on the line, so its effect
// on the registered outputs shows up at p+10.
module tb_hdlc_rx_deframer;

    localparam int MAXB = 4;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int N    = 16384;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          RxEN = 1'b0;
    logic          Rx = 1'b1;
    logic          Rx_FlagDetect;
    logic          Rx_AbortDetect;
    logic          Rx_AbortSignal;
    logic          Rx_ValidFrame;
    logic [7:0]    Rx_Data;
    logic          Rx_WrBuff;
    logic          Rx_EoF;
    logic          Rx_FrameError;
    logic          Rx_Overflow;
    logic [CW-1:0] Rx_FrameSize;

    hdlc_rx_deframer #(.MAX_BYTES(MAXB)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .RxEN           (RxEN),
        .Rx             (Rx),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_Data        (Rx_Data),
        .Rx_WrBuff      (Rx_WrBuff),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameError  (Rx_FrameError),
        .Rx_Overflow    (Rx_Overflow),
        .Rx_FrameSize   (Rx_FrameSize)
    );

    initial forever #5 Clk = ~Clk;

    // line history and expected outputs, indexed by cycle
    bit            hist    [N];
    bit            e_flag  [N];
    bit            e_abort [N];
    bit            e_asig  [N];
    bit            e_valid [N];
    bit            e_wr    [N];
    bit            e_eof   [N];
    bit            e_ferr  [N];
    bit            e_ovf   [N];
    logic [7:0]    e_data  [N];
    logic [CW-1:0] e_size  [N];

    // observed outputs, for the literal pins
    logic          l_flag  [N];
    logic          l_abort [N];
    logic          l_asig  [N];
    logic          l_valid [N];
    logic          l_wr    [N];
    logic          l_eof   [N];
    logic          l_ferr  [N];
    logic          l_ovf   [N];
    logic [7:0]    l_data  [N];
    logic [CW-1:0] l_size  [N];

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_bit = 0;
    int tx_ones = 0;

    // model state: mode 0 = hunting, 1 = flag seen, 2 = inside frame
    int         last_clear = -1;
    int         m_mode = 0;
    int         m_ones = 0;
    int         m_nbits = 0;
    int         m_count = 0;
    int         m_size = 0;
    logic [7:0] m_cur = 8'd0;
    logic [7:0] m_data = 8'd0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // line bits lost to a clear (or before time) look like idle ones
    function automatic bit fb(input int i);
        if (i < 0 || i <= last_clear) return 1'b1;
        return hist[i];
    endfunction

    // 8 bits ending at e, oldest bit in the MSB
    function automatic logic [7:0] pat(input int e);
        logic [7:0] v = 8'd0;
        for (int j = 0; j < 8; j++) v = {v[6:0], fb(e - 7 + j)};
        return v;
    endfunction

    function automatic bit in_flag(input int p);
        for (int e = p; e <= p + 7; e++)
            if (pat(e) == 8'h7E) return 1'b1;
        return 1'b0;
    endfunction

    task automatic deliver(input bit bt, input int c);
        if (!bt && m_ones == 5) begin
            m_ones = 0;
        end else begin
            m_ones = bt ? ((m_ones < 6) ? m_ones + 1 : 6) : 0;
            m_mode = 2;
            m_cur[m_nbits] = bt;
            m_nbits++;
            if (m_nbits == 8) begin
                if (m_count == MAXB) begin
                    e_ovf[c + 1] = 1'b1;
                end else begin
                    e_wr[c + 1] = 1'b1;
                    m_data = m_cur;
                    m_count++;
                end
                m_nbits = 0;
                m_cur = 8'd0;
            end
        end
    endtask

    task automatic model_step(input int c, input bit rx, input bit rstn, input bit en);
        int p;
        hist[c] = rx;
        e_flag[c + 1]  = 1'b0;
        e_abort[c + 1] = 1'b0;
        e_asig[c + 1]  = 1'b0;
        e_wr[c + 1]    = 1'b0;
        e_eof[c + 1]   = 1'b0;
        e_ferr[c + 1]  = 1'b0;
        e_ovf[c + 1]   = 1'b0;
        if (!rstn || !en) begin
            last_clear = c;
            m_mode = 0; m_ones = 0; m_nbits = 0; m_count = 0; m_size = 0;
            m_cur = 8'd0; m_data = 8'd0;
        end else begin
            e_flag[c + 1]  = (pat(c - 1) == 8'h7E);
            e_abort[c + 1] = (pat(c - 1) == 8'h7F);
            p = c - 9;
            if (e_flag[c]) begin
                if (m_mode == 2) begin
                    e_eof[c + 1]  = 1'b1;
                    e_ferr[c + 1] = (m_nbits != 0);
                    m_size = m_count;
                end
                m_mode = 1; m_ones = 0; m_nbits = 0; m_count = 0; m_cur = 8'd0;
            end else if (e_abort[c]) begin
                if (m_mode == 2) e_asig[c + 1] = 1'b1;
                m_mode = 0; m_ones = 0; m_nbits = 0; m_count = 0; m_cur = 8'd0;
            end else if (m_mode != 0 && p >= 0 && !in_flag(p)) begin
                deliver(fb(p), c);
            end
        end
        e_valid[c + 1] = (m_mode == 2);
        e_data[c + 1]  = m_data;
        e_size[c + 1]  = CW'(m_size);
    endtask

    task automatic tick(input bit rx, input bit rstn, input bit en);
        Rx = rx; Rst = rstn; RxEN = en;
        model_step(n, rx, rstn, en);
        last_bit = n;
        @(posedge Clk);
        #1;
        n++;
        if (n >= N - 2) begin
            $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", n, N - 2);
            $fatal(1, "cycle budget exhausted");
        end
        l_flag[n] = Rx_FlagDetect;   l_abort[n] = Rx_AbortDetect;
        l_asig[n] = Rx_AbortSignal;  l_valid[n] = Rx_ValidFrame;
        l_wr[n]   = Rx_WrBuff;       l_eof[n]   = Rx_EoF;
        l_ferr[n] = Rx_FrameError;   l_ovf[n]   = Rx_Overflow;
        l_data[n] = Rx_Data;         l_size[n]  = Rx_FrameSize;
        chk("flag_detect",  n, 32'(Rx_FlagDetect),  32'(e_flag[n]));
        chk("abort_detect", n, 32'(Rx_AbortDetect), 32'(e_abort[n]));
        chk("abort_signal", n, 32'(Rx_AbortSignal), 32'(e_asig[n]));
        chk("valid_frame",  n, 32'(Rx_ValidFrame),  32'(e_valid[n]));
        chk("wr_buff",      n, 32'(Rx_WrBuff),      32'(e_wr[n]));
        chk("rx_data",      n, 32'(Rx_Data),        32'(e_data[n]));
        chk("eof",          n, 32'(Rx_EoF),         32'(e_eof[n]));
        chk("frame_error",  n, 32'(Rx_FrameError),  32'(e_ferr[n]));
        chk("overflow",     n, 32'(Rx_Overflow),    32'(e_ovf[n]));
        chk("frame_size",   n, 32'(Rx_FrameSize),   32'(e_size[n]));
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) tick(1'b1, 1'b1, 1'b1);
    endtask

    task automatic send_raw(input logic [7:0] v, input int nb);
        for (int i = 0; i < nb; i++) tick(v[i], 1'b1, 1'b1);
    endtask

    task automatic send_flag();
        send_raw(8'h7E, 8);
        tx_ones = 0;
    endtask

    task automatic send_abort();
        send_raw(8'hFE, 8);
        tx_ones = 0;
    endtask

    task automatic send_data_bit(input bit b);
        tick(b, 1'b1, 1'b1);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 5) begin
            tick(1'b0, 1'b1, 1'b1);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    initial begin
        int t, k1, k2, tf, k, ta, k5, f6, r, nb, sel, wrs;

        repeat (3) tick(1'b1, 1'b0, 1'b0);
        idle(10);

        // lone flag on an idle line
        send_flag();
        t = last_bit;
        send_flag();
        chk("pin_flag_t1", t + 1, 32'(l_flag[t + 1]), 0);
        chk("pin_flag_t2", t + 2, 32'(l_flag[t + 2]), 1);
        chk("pin_flag_t3", t + 3, 32'(l_flag[t + 3]), 0);
        chk("pin_valid_sync", t + 3, 32'(l_valid[t + 3]), 0);

        // 0xA5, 0x3C, closing flag
        send_byte(8'hA5); k1 = last_bit;
        send_byte(8'h3C); k2 = last_bit;
        send_flag();      tf = last_bit;
        send_flag();
        chk("pin_wr_a5",   k1 + 10, 32'(l_wr[k1 + 10]),   1);
        chk("pin_data_a5", k1 + 10, 32'(l_data[k1 + 10]), 32'h A5);
        chk("pin_wr_3c",   k2 + 10, 32'(l_wr[k2 + 10]),   1);
        chk("pin_data_3c", k2 + 10, 32'(l_data[k2 + 10]), 32'h3C);
        chk("pin_eof_2",   tf + 3,  32'(l_eof[tf + 3]),   1);
        chk("pin_size_2",  tf + 3,  32'(l_size[tf + 3]),  2);
        chk("pin_ferr_2",  tf + 3,  32'(l_ferr[tf + 3]),  0);
        chk("pin_valid_drop", tf + 3, 32'(l_valid[tf + 3]), 0);

        // stuffed 0xFF
        send_byte(8'hFF); k = last_bit;
        send_flag();      tf = last_bit;
        send_flag();
        chk("pin_wr_ff",   k + 10, 32'(l_wr[k + 10]),   1);
        chk("pin_data_ff", k + 10, 32'(l_data[k + 10]), 32'hFF);
        chk("pin_size_ff", tf + 3, 32'(l_size[tf + 3]), 1);

        // 0x12 then abort
        send_byte(8'h12); k = last_bit;
        send_abort();     ta = last_bit;
        idle(4);
        chk("pin_data_12",   k + 10,  32'(l_data[k + 10]),  32'h12);
        chk("pin_abort_det", ta + 2,  32'(l_abort[ta + 2]), 1);
        chk("pin_valid_pre", ta + 2,  32'(l_valid[ta + 2]), 1);
        chk("pin_abort_sig", ta + 3,  32'(l_asig[ta + 3]),  1);
        chk("pin_valid_abt", ta + 3,  32'(l_valid[ta + 3]), 0);
        chk("pin_no_eof",    ta + 3,  32'(l_eof[ta + 3]),   0);

        // 12 data bits: misaligned frame
        send_flag();
        send_byte(8'h5A);
        send_data_bit(1'b0); send_data_bit(1'b1); send_data_bit(1'b1); send_data_bit(1'b0);
        send_flag(); tf = last_bit;
        send_flag();
        chk("pin_eof_12b",  tf + 3, 32'(l_eof[tf + 3]),  1);
        chk("pin_ferr_12b", tf + 3, 32'(l_ferr[tf + 3]), 1);
        chk("pin_size_12b", tf + 3, 32'(l_size[tf + 3]), 1);

        // five bytes into a four-byte limit
        f6 = last_bit;
        for (int b = 1; b <= 5; b++) send_byte(8'(b));
        k5 = last_bit;
        send_flag(); tf = last_bit;
        send_flag();
        wrs = 0;
        for (int c = f6 + 1; c <= tf + 2; c++) wrs += int'(l_wr[c]);
        chk("pin_ovf",      k5 + 10, 32'(l_ovf[k5 + 10]), 1);
        chk("pin_ovf_nowr", k5 + 10, 32'(l_wr[k5 + 10]),  0);
        chk("pin_wr_count", tf + 2,  32'(wrs),            4);
        chk("pin_size_ovf", tf + 3,  32'(l_size[tf + 3]), 4);

        // reset mid-frame
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        tick(1'b1, 1'b0, 1'b1); r = last_bit;
        idle(3);
        chk("pin_valid_before_rst", r,     32'(l_valid[r]),     1);
        chk("pin_valid_rst",        r + 1, 32'(l_valid[r + 1]), 0);
        chk("pin_size_rst",         r + 1, 32'(l_size[r + 1]),  0);
        chk("pin_data_rst",         r + 1, 32'(l_data[r + 1]),  0);

        // randomized frames
        for (int it = 0; it < 60; it++) begin
            idle($urandom_range(0, 9));
            repeat ($urandom_range(1, 2)) send_flag();
            nb = $urandom_range(0, 6);
            for (int i = 0; i < nb; i++)
                send_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 7)) send_data_bit(1'($urandom_range(0, 1)));
            sel = $urandom_range(0, 19);
            if (sel < 15) begin
                send_flag();
            end else if (sel < 18) begin
                send_abort();
            end else if (sel == 18) begin
                tick(1'b1, 1'b0, 1'b1);
                tx_ones = 0;
            end else begin
                repeat ($urandom_range(1, 3)) tick(1'b1, 1'b1, 1'b0);
                tx_ones = 0;
            end
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
Serial front end of the HDLC receive channel. It samples the Rx line, detects flags (01111110) and aborts (0 followed by seven 1s), and removes stuffed zeros. It assembles LSB-first data bytes and streams them to the Rx buffer/control stage with write strobes and frame-status pulses. It generates the Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame and Rx_AbortSignal behaviour that the Rx concurrent assertions check.

Parameters:
MAX_BYTES, 128, maximum data bytes per frame accepted before overflow
CNT_W, $clog2(MAX_BYTES+1), width of the frame byte counter

Ports:
Clk  input  1  system clock, all logic on posedge
Rst  input  1  synchronous reset, active-low
RxEN  input  1  receiver enable; low behaves as reset of all internal state
Rx  input  1  serial line bit, sampled every Clk while RxEN=1
Rx_FlagDetect  output  1  one-cycle pulse per detected flag
Rx_AbortDetect  output  1  one-cycle pulse per detected abort pattern
Rx_AbortSignal  output  1  one-cycle pulse, cycle after Rx_AbortDetect when frame was valid
Rx_ValidFrame  output  1  high while inside a frame (after opening flag, before closing flag or abort)
Rx_Data  output  8  assembled data byte, valid with Rx_WrBuff
Rx_WrBuff  output  1  one-cycle byte write strobe
Rx_EoF  output  1  one-cycle end-of-frame pulse
Rx_FrameError  output  1  one-cycle pulse with Rx_EoF when the frame is not byte-aligned
Rx_Overflow  output  1  one-cycle pulse when a byte beyond MAX_BYTES completes
Rx_FrameSize  output  CNT_W  bytes in last completed frame, updated with Rx_EoF

Behaviour:
- Reset (Rst=0 at posedge) or RxEN=0: all outputs 0, window, counters and FSM cleared, Rx_FrameSize=0.
- 8-bit window: every Clk, Rx shifts into the window. Pattern compare is registered. Let t be the cycle in which the final bit of a pattern is on Rx: Rx_FlagDetect (window=01111110) or Rx_AbortDetect (0 then 1111111) is high in cycle t+2, exactly one cycle.
- Continuous 1s after an abort produce no further AbortDetect until a 0 is seen.
- FSM states: IDLE, SYNC, FRAME.
  - IDLE: waits for flag -> SYNC.
  - SYNC: flag received, no data yet. Another flag keeps SYNC (inter-frame fill, no EoF). A first data bit -> FRAME, and Rx_ValidFrame rises with that bit's delivery.
  - FRAME: flag -> Rx_EoF in the cycle after Rx_FlagDetect, Rx_ValidFrame drops in the same cycle, go to SYNC. Abort -> go to IDLE, Rx_ValidFrame drops in the cycle after Rx_AbortDetect, and Rx_AbortSignal pulses that same cycle. No EoF on abort.
  - Abort in IDLE or SYNC: Rx_AbortDetect only, no AbortSignal, go to IDLE.
- Data delivery:
  - Bits leaving the window are data bits in SYNC/FRAME, except bits belonging to a flag.
  - A 0 exiting after five consecutive exiting 1s is discarded (destuffing); the ones-run counter resets on any 0.
  - The first data bit goes to Rx_Data[0].
  - Fixed latency: the 8th data bit on Rx in cycle k gives Rx_WrBuff and Rx_Data in cycle k+10.
- Closing flag:
  - Rx_FrameError=1 with Rx_EoF if the residual bit count is not 0; the partial byte is discarded.
  - Rx_FrameSize is set to the byte count at Rx_EoF, and the byte counter clears.
- Overflow: a byte completing when the count is already MAX_BYTES raises Rx_Overflow, gives no Rx_WrBuff, and the count saturates. The frame continues.
- Simultaneous last-byte WrBuff and FlagDetect are legal (both in cycle k+10). EoF always follows one cycle later.
- Reset or RxEN deassert mid-frame: immediate clear, no EoF or AbortSignal.

Decomposition:
- Package hdlc_rx_pkg:
  - FLAG_PATTERN=8'b0111_1110, ABORT_ONES=7, STUFF_ONES=5.
  - FSM enum rx_state_t {IDLE, SYNC, FRAME}.
- Sub-module hdlc_rx_pattern_detect: window shift register plus registered flag/abort compare, producing Rx_FlagDetect and Rx_AbortDetect and the exiting bit.
- Top-level: FSM, destuffing, byte assembly, counters.

Test Plan:
- Idle all-1s, then 01111110 -> Rx_FlagDetect high exactly 2 cycles after the final 0; Rx_ValidFrame stays 0.
- Flag, bytes 0xA5 0x3C, flag -> Rx_WrBuff twice, Rx_Data=0xA5 then 0x3C, each 10 cycles after its last bit. Then Rx_EoF, Rx_FrameSize=2, Rx_FrameError=0.
- Flag, data 0xFF sent stuffed (11111 0 111), flag -> one byte 0xFF, stuffed 0 removed, Rx_FrameSize=1.
- Flag, 0x12, then 0 followed by 1111111 -> Rx_AbortDetect, next cycle Rx_AbortSignal=1 and Rx_ValidFrame=0; no Rx_EoF.
- Flag, 12 data bits, flag -> Rx_EoF with Rx_FrameError=1, Rx_FrameSize=1.
- MAX_BYTES=4, frame of 5 bytes -> 4 Rx_WrBuff, Rx_Overflow on the 5th. Separately: deassert Rst mid-frame -> all outputs 0 the next cycle.
